// File: rtl/digit_shift_reg_pkg.sv
// rtl/digit_shift_reg_pkg.sv - shared operation type and default sizes for the digit register
package digit_reg_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_DEPTH = 4;

   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_PUSH = 2'd1,
      OP_DEL  = 2'd2,
      OP_CLR  = 2'd3
   } op_t;

endpackage

// File: rtl/digit_shift_reg_if.sv
// rtl/digit_shift_reg_if.sv - strobe/digit bus between a keypad source and the digit register
interface digit_shift_reg_if
   import digit_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);

   localparam int CW = $clog2(DEPTH + 1);

   logic                     en;
   logic [WIDTH-1:0]         din;
   logic                     del;
   logic                     clr;
   logic [DEPTH*WIDTH-1:0]   q;
   logic [CW-1:0]            count;
   logic                     empty;
   logic                     full;
   logic                     ovf;

   modport master (
      output en, din, del, clr,
      input  q, count, empty, full, ovf
   );

   modport slave (
      input  en, din, del, clr,
      output q, count, empty, full, ovf
   );

endinterface

// File: rtl/digit_shift_reg_cell.sv
// rtl/digit_shift_reg_cell.sv - one digit slot: WIDTH-bit register with load enable
module digit_reg_cell #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else if (load_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/digit_shift_reg.sv
// rtl/digit_shift_reg.sv - keypad digit entry register with push, backspace and clear
// Slot 0 holds the newest digit; all slots load together on any state-changing operation.
module digit_shift_reg
   import digit_reg_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int OVERWRITE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   digit_shift_reg_if.slave  bus
);

   localparam int CW = $clog2(DEPTH + 1);

   op_t              op;
   logic             load;
   logic [WIDTH-1:0] slot_q [DEPTH];
   logic [WIDTH-1:0] slot_d [DEPTH];
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             ovf_q;
   logic             ovf_d;
   logic             full;

   assign full = (count_q == CW'(DEPTH));

   always_comb begin
      op = OP_HOLD;
      if (bus.clr) begin
         op = OP_CLR;
      end else if (bus.del) begin
         op = OP_DEL;
      end else if (bus.en) begin
         op = OP_PUSH;
      end
   end

   always_comb begin
      load    = 1'b0;
      count_d = count_q;
      ovf_d   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_d[i] = slot_q[i];
      end
      case (op)
         OP_CLR: begin
            load    = 1'b1;
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
               slot_d[i] = '0;
            end
         end
         OP_DEL: begin
            if (count_q != '0) begin
               load    = 1'b1;
               count_d = count_q - CW'(1);
               for (int i = 0; i < DEPTH - 1; i++) begin
                  slot_d[i] = slot_q[i+1];
               end
               slot_d[DEPTH-1] = '0;
            end
         end
         OP_PUSH: begin
            ovf_d = full;
            // A full push without overwrite leaves the digits untouched.
            if (!full || (OVERWRITE != 0)) begin
               load      = 1'b1;
               slot_d[0] = bus.din;
               for (int i = 1; i < DEPTH; i++) begin
                  slot_d[i] = slot_q[i-1];
               end
               if (!full) begin
                  count_d = count_q + CW'(1);
               end
            end
         end
         default: begin
         end
      endcase
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      digit_reg_cell #(
         .WIDTH (WIDTH)
      ) u_cell (
         .clk_i  (clk),
         .rst_ni (rst_n),
         .load_i (load),
         .d_i    (slot_d[g]),
         .q_o    (slot_q[g])
      );
      assign bus.q[g*WIDTH +: WIDTH] = slot_q[g];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.count = count_q;
   assign bus.empty = (count_q == '0);
   assign bus.full  = full;
   assign bus.ovf   = ovf_q;

endmodule

// File: doc/digit_shift_reg.md
DIGIT_SHIFT_REG -- requirements
Module: digit_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4: bits per stored digit (one hex key code).
REQ-002 Parameter DEPTH, default 4: number of digits held; legal range 2..16.
REQ-003 Parameter OVERWRITE, default 1: 1 = a push when full discards the oldest digit; 0 = a push when full is ignored.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  push strobe; when high, shift din into the newest-digit slot.
REQ-007 din  input  WIDTH  digit to push.
REQ-008 del  input  1  backspace strobe; when high, remove the newest digit.
REQ-009 clr  input  1  synchronous clear of all digits and of count.
REQ-010 q  output  DEPTH*WIDTH  stored digits; q[WIDTH-1:0] is the newest digit, the top slice is the oldest.
REQ-011 count  output  $clog2(DEPTH+1)  number of valid digits, 0..DEPTH.
REQ-012 empty  output  1  high when count == 0.
REQ-013 full  output  1  high when count == DEPTH.
REQ-014 ovf  output  1  one-cycle pulse on a push attempted while full.

Function
REQ-015 All outputs SHALL be registered or derived combinationally from registered state only; there is no input-to-output combinational path.
REQ-016 Each operation SHALL take effect on the first rising clk edge at which its strobe is sampled high; q and count show the result one cycle after the strobe.
REQ-017 Operation priority SHALL be clr > del > en; a lower-priority strobe active in the same cycle SHALL be ignored with no side effect, including no ovf.
REQ-018 Push, not full: q SHALL become {q[(DEPTH-1)*WIDTH-1:0], din}, and count SHALL increment by 1.
REQ-019 Push, full, OVERWRITE=1: q SHALL shift as in REQ-018, discarding the oldest digit; count SHALL stay DEPTH; ovf SHALL be high for one cycle.
REQ-020 Push, full, OVERWRITE=0: q and count SHALL be unchanged; ovf SHALL be high for one cycle.
REQ-021 Delete, not empty: q SHALL shift right by WIDTH with zero fill in the oldest slot, and count SHALL decrement by 1.
REQ-022 Delete, empty: no change; no flag asserted.
REQ-023 Clear: q SHALL be all zeros and count SHALL be 0 on the next edge.
REQ-024 With no strobe active, all state SHALL hold.
REQ-025 ovf SHALL return low on the cycle after its pulse unless the next push is also a full push.
REQ-026 Digit slots beyond count SHALL always read zero.

Reset
REQ-027 Asserting rst_n low SHALL immediately, without waiting for clk, force q = 0, count = 0, empty = 1, full = 0, ovf = 0.
REQ-028 Reset asserted mid-operation SHALL discard the pending operation.
REQ-029 The first operation after reset release SHALL be the first strobe sampled at a rising edge while rst_n is high.

Structure
REQ-030 A shared package digit_reg_pkg SHALL hold the operation enum (OP_HOLD, OP_PUSH, OP_DEL, OP_CLR) and the default WIDTH and DEPTH constants.
REQ-031 Priority decode SHALL produce one op_t value per cycle, which drives a single case statement.
REQ-032 A sub-module digit_reg_cell SHALL provide one WIDTH-bit register with load enable and asynchronous active-low reset, instantiated DEPTH times.
REQ-033 count, full, empty and ovf SHALL be held in the top-level module.

Verification
REQ-034 Reset, then push 0x1, 0x2, 0x3 -> q = 0x0123, count = 3, full = 0, empty = 0.
REQ-035 Push 0x1..0x5 with OVERWRITE=1 -> q = 0x2345, count = 4, ovf pulses exactly once, on the fifth push.
REQ-036 Same sequence with OVERWRITE=0 -> q = 0x1234, count = 4, ovf pulses once.
REQ-037 From q = 0x0123, count = 3, assert del and en together with din = 0xF -> q = 0x0012, count = 2, ovf = 0; a further three del -> q = 0, empty = 1.
REQ-038 From q = 0x1234, assert clr, del and en together -> q = 0, count = 0 after one edge.
REQ-039 Pull rst_n low between clock edges while en is high -> outputs zero before the next edge; no push occurs on that edge.
